// File: rtl/web1_lp_pkg.sv
// ----------------------------------------------------------------------------
// Module  : web1_lp_pkg
// Brief   : Shared state encoding and default timing for the web1 LP sequencer.
// Rev     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package web1_lp_pkg;

  typedef enum logic [3:0] {
    LP_ACTIVE = 4'd0,
    LP_ISO    = 4'd1,
    LP_RET    = 4'd2,
    LP_PWR_DN = 4'd3,
    LP_OFF    = 4'd4,
    LP_PWR_UP = 4'd5,
    LP_DE_RET = 4'd6,
    LP_DE_ISO = 4'd7,
    LP_CLR_HI = 4'd8,
    LP_CLR_LO = 4'd9
  } lp_state_e;

  localparam int unsigned C_ISO_DLY_DEF     = 4;
  localparam int unsigned C_RET_DLY_DEF     = 4;
  localparam int unsigned C_PWR_TIMEOUT_DEF = 255;
  localparam int unsigned C_CLR_HOLD_DEF    = 4;
  localparam int unsigned C_CNT_W_DEF       = 8;

endpackage

`default_nettype wire

// File: rtl/ftc_double_rank_synchronizer_async.sv
// ----------------------------------------------------------------------------
// Module  : ftc_double_rank_synchronizer_async
// Brief   : Two-flop synchronizer with async reset value; test mode bypasses it.
// Rev     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ftc_double_rank_synchronizer_async #(
  parameter int               WIDTH  = 1,
  parameter logic [WIDTH-1:0] RSTVAL = '0
) (
  input  logic             clkclk,
  input  logic             sysreset_n,
  input  logic             systest_mode_async,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_rank1;
  logic [WIDTH-1:0] r_rank2;

  always_ff @(posedge clkclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      r_rank1 <= RSTVAL;
      r_rank2 <= RSTVAL;
    end else begin
      r_rank1 <= i_d;
      r_rank2 <= r_rank1;
    end
  end

  // In async test mode the input is already synchronous to the tester clock.
  assign o_q = systest_mode_async ? i_d : r_rank2;

endmodule

`default_nettype wire

// File: rtl/web1_lp_seq.sv
// ----------------------------------------------------------------------------
// Module  : web1_lp_seq
// Brief   : Low-power entry/exit sequencer driving iso/ret/clk/power handshake.
// Rev     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module web1_lp_seq
  import web1_lp_pkg::*;
#(
  parameter int unsigned ISO_DLY     = C_ISO_DLY_DEF,
  parameter int unsigned RET_DLY     = C_RET_DLY_DEF,
  parameter int unsigned PWR_TIMEOUT = C_PWR_TIMEOUT_DEF,
  parameter int unsigned CLR_HOLD    = C_CLR_HOLD_DEF,
  parameter int unsigned CNT_W       = C_CNT_W_DEF
) (
  input  logic       clkclk,
  input  logic       sysreset_n,
  input  logic       systest_mode_cgm,
  input  logic       systest_mode_async,
  input  logic       wake,
  input  logic       activate_low_pwr,
  input  logic       epu_enable,
  input  logic       pwr_ack,
  input  logic       err_clr,
  output logic       clear_function,
  output logic       iso_en,
  output logic       ret_en,
  output logic       pwr_req,
  output logic       clk_en,
  output logic       busy,
  output logic       lp_error,
  output logic [3:0] lp_state
);

  lp_state_e        r_state;
  lp_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_load;
  logic             w_cnt_zero;
  logic             w_timeout;
  logic             w_ack_s;

  logic r_iso_en, r_ret_en, r_pwr_req, r_clk_en, r_clear, r_busy, r_lp_error;
  logic w_iso_nxt, w_ret_nxt, w_pwr_nxt, w_clk_nxt, w_clear_nxt, w_busy_nxt;
  logic w_err_nxt;

  ftc_double_rank_synchronizer_async #(
    .WIDTH  (1),
    .RSTVAL (1'b1)
  ) u_ack_sync (
    .clkclk             (clkclk),
    .sysreset_n         (sysreset_n),
    .systest_mode_async (systest_mode_async),
    .i_d                (pwr_ack),
    .o_q                (w_ack_s)
  );

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      LP_ACTIVE: if (activate_low_pwr && epu_enable && !wake) w_state_nxt = LP_ISO;
      LP_ISO: begin
        if (wake)            w_state_nxt = LP_DE_ISO;
        else if (w_cnt_zero) w_state_nxt = LP_RET;
      end
      LP_RET: begin
        if (wake)            w_state_nxt = LP_DE_RET;
        else if (w_cnt_zero) w_state_nxt = LP_PWR_DN;
      end
      LP_PWR_DN: begin
        if (wake)          w_state_nxt = LP_PWR_UP;
        else if (!w_ack_s) w_state_nxt = LP_OFF;
        else if (w_cnt_zero) begin
          w_timeout   = 1'b1;
          w_state_nxt = LP_PWR_UP;
        end
      end
      LP_OFF: if (wake) w_state_nxt = LP_PWR_UP;
      LP_PWR_UP: begin
        // A missing ack still completes the exit so the domain is never stranded.
        if (w_ack_s) w_state_nxt = LP_DE_RET;
        else if (w_cnt_zero) begin
          w_timeout   = 1'b1;
          w_state_nxt = LP_DE_RET;
        end
      end
      LP_DE_RET: if (w_cnt_zero) w_state_nxt = LP_DE_ISO;
      LP_DE_ISO: if (w_cnt_zero) w_state_nxt = LP_CLR_HI;
      LP_CLR_HI: if (w_cnt_zero) w_state_nxt = LP_CLR_LO;
      LP_CLR_LO: if (w_cnt_zero) w_state_nxt = LP_ACTIVE;
      default:   w_state_nxt = LP_ACTIVE;
    endcase
  end

  // Shared down-counter: reloads with (delay-1) whenever a new state is entered.
  always_comb begin
    w_cnt_load = '0;
    case (w_state_nxt)
      LP_ISO, LP_DE_ISO:    w_cnt_load = CNT_W'(ISO_DLY - 1);
      LP_RET, LP_DE_RET:    w_cnt_load = CNT_W'(RET_DLY - 1);
      LP_PWR_DN, LP_PWR_UP: w_cnt_load = CNT_W'(PWR_TIMEOUT - 1);
      LP_CLR_HI, LP_CLR_LO: w_cnt_load = CNT_W'(CLR_HOLD - 1);
      default:              w_cnt_load = '0;
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = w_cnt_load;
    else if (!w_cnt_zero)       w_cnt_nxt = r_cnt - 1'b1;
    else                        w_cnt_nxt = r_cnt;
  end

  always_comb begin
    w_iso_nxt   = 1'b0;
    w_ret_nxt   = 1'b0;
    w_pwr_nxt   = 1'b1;
    w_clk_nxt   = 1'b0;
    w_clear_nxt = 1'b0;
    w_busy_nxt  = (w_state_nxt != LP_ACTIVE);
    case (w_state_nxt)
      LP_ACTIVE:            w_clk_nxt = 1'b1;
      LP_ISO, LP_DE_RET:    w_iso_nxt = 1'b1;
      LP_RET, LP_PWR_UP: begin
        w_iso_nxt = 1'b1;
        w_ret_nxt = 1'b1;
      end
      LP_PWR_DN, LP_OFF: begin
        w_iso_nxt = 1'b1;
        w_ret_nxt = 1'b1;
        w_pwr_nxt = 1'b0;
      end
      LP_CLR_HI: begin
        w_clk_nxt   = 1'b1;
        w_clear_nxt = 1'b1;
      end
      LP_CLR_LO:            w_clk_nxt = 1'b1;
      default:              w_clk_nxt = 1'b0;
    endcase
    if (systest_mode_cgm) w_clk_nxt = 1'b1;
    if (w_timeout)    w_err_nxt = 1'b1;
    else if (err_clr) w_err_nxt = 1'b0;
    else              w_err_nxt = r_lp_error;
  end

  always_ff @(posedge clkclk or negedge sysreset_n) begin
    if (!sysreset_n) begin
      r_state    <= LP_ACTIVE;
      r_cnt      <= '0;
      r_iso_en   <= 1'b0;
      r_ret_en   <= 1'b0;
      r_pwr_req  <= 1'b1;
      r_clk_en   <= 1'b1;
      r_clear    <= 1'b0;
      r_busy     <= 1'b0;
      r_lp_error <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_iso_en   <= w_iso_nxt;
      r_ret_en   <= w_ret_nxt;
      r_pwr_req  <= w_pwr_nxt;
      r_clk_en   <= w_clk_nxt;
      r_clear    <= w_clear_nxt;
      r_busy     <= w_busy_nxt;
      r_lp_error <= w_err_nxt;
    end
  end

  assign clear_function = r_clear;
  assign iso_en         = r_iso_en;
  assign ret_en         = r_ret_en;
  assign pwr_req        = r_pwr_req;
  assign clk_en         = r_clk_en;
  assign busy           = r_busy;
  assign lp_error       = r_lp_error;
  assign lp_state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_web1_lp_seq.sv
// ----------------------------------------------------------------------------
// Module  : tb_web1_lp_seq
// Brief   : Directed bench for web1_lp_seq with a delayed power-ack model.
// Rev     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_web1_lp_seq;

  logic       clkclk = 1'b0;
  logic       sysreset_n = 1'b0;
  logic       systest_mode_cgm = 1'b0;
  logic       systest_mode_async = 1'b0;
  logic       wake = 1'b0;
  logic       activate_low_pwr = 1'b0;
  logic       epu_enable = 1'b0;
  logic       pwr_ack = 1'b1;
  logic       err_clr = 1'b0;
  logic       clear_function, iso_en, ret_en, pwr_req, clk_en, busy, lp_error;
  logic [3:0] lp_state;

  int total = 0;
  int bad   = 0;

  logic [4:0] hist  = 5'b11111;
  bit         stuck = 1'b0;

  web1_lp_seq #(
    .ISO_DLY     (4),
    .RET_DLY     (4),
    .PWR_TIMEOUT (16),
    .CLR_HOLD    (4),
    .CNT_W       (8)
  ) dut (
    .clkclk             (clkclk),
    .sysreset_n         (sysreset_n),
    .systest_mode_cgm   (systest_mode_cgm),
    .systest_mode_async (systest_mode_async),
    .wake               (wake),
    .activate_low_pwr   (activate_low_pwr),
    .epu_enable         (epu_enable),
    .pwr_ack            (pwr_ack),
    .err_clr            (err_clr),
    .clear_function     (clear_function),
    .iso_en             (iso_en),
    .ret_en             (ret_en),
    .pwr_req            (pwr_req),
    .clk_en             (clk_en),
    .busy               (busy),
    .lp_error           (lp_error),
    .lp_state           (lp_state)
  );

  always #5 clkclk = ~clkclk;

  // Power switch: ack follows pwr_req a few cycles later, or sticks high.
  always @(negedge clkclk) begin
    hist    = {hist[3:0], pwr_req};
    pwr_ack = stuck ? 1'b1 : hist[4];
  end

  task automatic step();
    @(posedge clkclk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_active(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (lp_state == 4'd0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    sysreset_n = 1'b0;
    steps(3);
    total++;
    if ({lp_state, clk_en, pwr_req, iso_en, ret_en, clear_function, lp_error, busy} !== 11'b0000_11_00000) begin
      bad++;
      $display("FAIL reset_vals: got %b want %b",
               {lp_state, clk_en, pwr_req, iso_en, ret_en, clear_function, lp_error, busy}, 11'b0000_11_00000);
    end
    sysreset_n = 1'b1;
    steps(8);
    total++;
    if (lp_state !== 4'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: state=%0d busy=%b want 0/0", lp_state, busy);
    end
  endtask

  task automatic test_full_cycle();
    bit ok;
    epu_enable = 1'b1;
    activate_low_pwr = 1'b1;
    step();
    activate_low_pwr = 1'b0;
    total++;
    if (lp_state !== 4'd1 || iso_en !== 1'b1 || clk_en !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL entry_iso: state=%0d iso=%b clk_en=%b busy=%b want 1/1/0/1", lp_state, iso_en, clk_en, busy);
    end
    steps(3);
    total++;
    if (lp_state !== 4'd1) begin bad++; $display("FAIL iso_len: state=%0d want 1", lp_state); end
    step();
    total++;
    if (lp_state !== 4'd2 || ret_en !== 1'b1) begin
      bad++;
      $display("FAIL enter_ret: state=%0d ret=%b want 2/1", lp_state, ret_en);
    end
    steps(4);
    total++;
    if (lp_state !== 4'd3 || pwr_req !== 1'b0) begin
      bad++;
      $display("FAIL enter_pwr_dn: state=%0d pwr_req=%b want 3/0", lp_state, pwr_req);
    end
    steps(6);
    total++;
    if (lp_state !== 4'd3) begin bad++; $display("FAIL pwr_dn_wait: state=%0d want 3", lp_state); end
    step();
    total++;
    if (lp_state !== 4'd4 || iso_en !== 1'b1 || ret_en !== 1'b1) begin
      bad++;
      $display("FAIL enter_off: state=%0d iso=%b ret=%b want 4/1/1", lp_state, iso_en, ret_en);
    end
    steps(2);
    wake = 1'b1;
    step();
    wake = 1'b0;
    total++;
    if (lp_state !== 4'd5 || pwr_req !== 1'b1) begin
      bad++;
      $display("FAIL wake_pwr_up: state=%0d pwr_req=%b want 5/1", lp_state, pwr_req);
    end
    steps(6);
    total++;
    if (lp_state !== 4'd5) begin bad++; $display("FAIL pwr_up_wait: state=%0d want 5", lp_state); end
    step();
    total++;
    if (lp_state !== 4'd6 || ret_en !== 1'b0 || iso_en !== 1'b1) begin
      bad++;
      $display("FAIL enter_de_ret: state=%0d ret=%b iso=%b want 6/0/1", lp_state, ret_en, iso_en);
    end
    steps(4);
    total++;
    if (lp_state !== 4'd7 || iso_en !== 1'b0 || clk_en !== 1'b0) begin
      bad++;
      $display("FAIL enter_de_iso: state=%0d iso=%b clk_en=%b want 7/0/0", lp_state, iso_en, clk_en);
    end
    steps(4);
    total++;
    if (lp_state !== 4'd8 || clear_function !== 1'b1 || clk_en !== 1'b1) begin
      bad++;
      $display("FAIL enter_clr_hi: state=%0d clr=%b clk_en=%b want 8/1/1", lp_state, clear_function, clk_en);
    end
    steps(3);
    total++;
    if (clear_function !== 1'b1) begin bad++; $display("FAIL clr_hold: clr=%b want 1", clear_function); end
    step();
    total++;
    if (lp_state !== 4'd9 || clear_function !== 1'b0) begin
      bad++;
      $display("FAIL enter_clr_lo: state=%0d clr=%b want 9/0", lp_state, clear_function);
    end
    steps(3);
    total++;
    if (lp_state !== 4'd9) begin bad++; $display("FAIL clr_lo_len: state=%0d want 9", lp_state); end
    step();
    total++;
    if (lp_state !== 4'd0 || busy !== 1'b0 || clk_en !== 1'b1) begin
      bad++;
      $display("FAIL back_active: state=%0d busy=%b clk_en=%b want 0/0/1", lp_state, busy, clk_en);
    end
    run_to_active(2, ok);
    steps(8);
  endtask

  task automatic test_gating();
    int moved;
    moved = 0;
    epu_enable = 1'b0;
    activate_low_pwr = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (lp_state !== 4'd0) moved++;
    end
    total++;
    if (moved !== 0) begin bad++; $display("FAIL gate_epu: cycles_left_active=%0d want 0", moved); end
    moved = 0;
    epu_enable = 1'b1;
    wake = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (lp_state !== 4'd0) moved++;
    end
    total++;
    if (moved !== 0) begin bad++; $display("FAIL gate_wake: cycles_left_active=%0d want 0", moved); end
    activate_low_pwr = 1'b0;
    wake = 1'b0;
    steps(2);
  endtask

  task automatic test_abort_ret();
    bit dropped, clr_seen, ok;
    dropped = 1'b0;
    clr_seen = 1'b0;
    activate_low_pwr = 1'b1;
    step();
    activate_low_pwr = 1'b0;
    steps(5);
    wake = 1'b1;
    step();
    wake = 1'b0;
    total++;
    if (lp_state !== 4'd6 || ret_en !== 1'b0) begin
      bad++;
      $display("FAIL abort_ret: state=%0d ret=%b want 6/0", lp_state, ret_en);
    end
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (pwr_req !== 1'b1) dropped = 1'b1;
      if (clear_function === 1'b1) clr_seen = 1'b1;
      step();
      if (lp_state == 4'd0) begin ok = 1'b1; break; end
    end
    total++;
    if (dropped || !clr_seen || !ok) begin
      bad++;
      $display("FAIL abort_ret_exit: pwr_dropped=%b clr_seen=%b done=%b want 0/1/1", dropped, clr_seen, ok);
    end
    steps(8);
  endtask

  task automatic test_timeout();
    bit ok;
    stuck = 1'b1;
    activate_low_pwr = 1'b1;
    step();
    activate_low_pwr = 1'b0;
    steps(8);
    total++;
    if (lp_state !== 4'd3) begin bad++; $display("FAIL to_pwr_dn: state=%0d want 3", lp_state); end
    steps(15);
    total++;
    if (lp_state !== 4'd3 || lp_error !== 1'b0) begin
      bad++;
      $display("FAIL to_last_dn: state=%0d err=%b want 3/0", lp_state, lp_error);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    total++;
    if (lp_state !== 4'd5 || lp_error !== 1'b1) begin
      bad++;
      $display("FAIL to_fire: state=%0d err=%b want 5/1", lp_state, lp_error);
    end
    step();
    total++;
    if (lp_state !== 4'd6 || lp_error !== 1'b1) begin
      bad++;
      $display("FAIL to_sticky: state=%0d err=%b want 6/1", lp_state, lp_error);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    total++;
    if (lp_error !== 1'b0) begin bad++; $display("FAIL err_clr: err=%b want 0", lp_error); end
    run_to_active(40, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL to_exit: returned=%b want 1", ok); end
    stuck = 1'b0;
    steps(8);
  endtask

  task automatic test_reset_mid();
    bit ok;
    ok = 1'b0;
    activate_low_pwr = 1'b1;
    step();
    activate_low_pwr = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (lp_state == 4'd4) begin ok = 1'b1; break; end
    end
    total++;
    if (!ok) begin bad++; $display("FAIL reach_off: state=%0d want 4", lp_state); end
    #2 sysreset_n = 1'b0;
    #1;
    total++;
    if ({lp_state, pwr_req, iso_en, ret_en, clk_en, busy} !== 9'b0000_1001_0) begin
      bad++;
      $display("FAIL async_reset: got %b want %b", {lp_state, pwr_req, iso_en, ret_en, clk_en, busy}, 9'b0000_1001_0);
    end
    step();
    sysreset_n = 1'b1;
    steps(10);
  endtask

  task automatic test_guard_cgm();
    int reentered;
    bit ok;
    reentered = 0;
    systest_mode_cgm = 1'b1;
    epu_enable = 1'b1;
    activate_low_pwr = 1'b1;
    step();
    total++;
    if (lp_state !== 4'd1 || clk_en !== 1'b1) begin
      bad++;
      $display("FAIL cgm_iso: state=%0d clk_en=%b want 1/1", lp_state, clk_en);
    end
    systest_mode_cgm = 1'b0;
    wake = 1'b1;
    step();
    wake = 1'b0;
    total++;
    if (lp_state !== 4'd7) begin bad++; $display("FAIL abort_iso: state=%0d want 7", lp_state); end
    steps(7);
    for (int i = 0; i < 4; i++) begin
      step();
      if (lp_state !== 4'd9) reentered++;
    end
    total++;
    if (reentered !== 0) begin bad++; $display("FAIL guard_clr_lo: off_state_cycles=%0d want 0", reentered); end
    step();
    total++;
    if (lp_state !== 4'd0) begin bad++; $display("FAIL guard_active: state=%0d want 0", lp_state); end
    step();
    total++;
    if (lp_state !== 4'd1) begin bad++; $display("FAIL reentry: state=%0d want 1", lp_state); end
    activate_low_pwr = 1'b0;
    wake = 1'b1;
    step();
    wake = 1'b0;
    run_to_active(40, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL guard_exit: returned=%b want 1", ok); end
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_gating();
    test_abort_ret();
    test_timeout();
    test_reset_mid();
    test_guard_cgm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
